// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word
// and the location/default of the opcode field that stops fetching.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Opcode occupies the top OPCODE_BITS of every instruction word.
    localparam int OPCODE_BITS = 4;
    localparam logic [OPCODE_BITS-1:0] DEFAULT_HALT_OPCODE = 4'hF;

    // NOP is all zeros; sliced down to the actual instruction width by users.
    localparam int MAX_INSTR_WIDTH = 64;
    localparam logic [MAX_INSTR_WIDTH-1:0] NOP_WORD = '0;

endpackage

// File: rtl/instr_mem.sv
// Program storage: synchronous write, combinational read, never cleared by reset.
module instr_mem #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [ADDR_BITS-1:0]   waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [ADDR_BITS-1:0]   raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks program memory from address 0 on start, issues
// one registered word per cycle, inserts bubbles on stall and stops on HALT opcode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                      INSTR_WIDTH = 20,
    parameter int                      ADDR_BITS   = 5,
    parameter logic [OPCODE_BITS-1:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   stall,
    input  logic                   load_en,
    input  logic [ADDR_BITS-1:0]   load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   halted,
    output logic [7:0]             issue_count
);

    localparam logic [INSTR_WIDTH-1:0] NOP = NOP_WORD[INSTR_WIDTH-1:0];

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   pc_reg, pc_next;
    logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
    logic                   valid_reg, valid_next;
    logic [7:0]             count_reg, count_next;

    logic [INSTR_WIDTH-1:0] mem_word;
    logic [OPCODE_BITS-1:0] fetch_opcode;
    logic                   mem_we;

    // Loading is only allowed while the fetch engine is not reading memory.
    assign mem_we = load_en && (state_reg != ST_RUN);

    instr_mem #(
        .INSTR_WIDTH(INSTR_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_instr_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(load_addr),
        .wdata(load_data),
        .raddr(pc_reg),
        .rdata(mem_word)
    );

    assign fetch_opcode = mem_word[INSTR_WIDTH-1 -: OPCODE_BITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            instr_reg <= NOP;
            valid_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = NOP;
        valid_next = 1'b0;
        count_next = count_reg;

        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_next = ST_RUN;
                        pc_next    = '0;
                        count_next = '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (fetch_opcode == HALT_OPCODE) begin
                            state_next = ST_HALT;
                        end else begin
                            instr_next = mem_word;
                            valid_next = 1'b1;
                            pc_next    = pc_reg + 1'b1;
                            if (count_reg != 8'hFF) begin
                                count_next = count_reg + 8'd1;
                            end
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign instruction = instr_reg;
    assign instr_valid = valid_reg;
    assign pc          = pc_reg;
    assign halted      = (state_reg == ST_HALT);
    assign issue_count = count_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: program load, halt, wrap, stall, load gating,
// async reset, abort priority and counter saturation.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        stall;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [19:0] load_data;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [4:0]  pc;
    logic        halted;
    logic [7:0]  issue_count;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .stall      (stall),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc         (pc),
        .halted     (halted),
        .issue_count(issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [4:0] a, input logic [19:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    function automatic logic [19:0] fill_word(input int i);
        logic [19:0] w;
        w = 20'h10000 | 20'(i);
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #12;
        total++;
        if ({instruction, instr_valid, pc, halted, issue_count} !== {20'h0, 1'b0, 5'd0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_state: got instr=%h v=%b pc=%0d h=%b cnt=%0d want 0/0/0/0/0",
                     instruction, instr_valid, pc, halted, issue_count);
        end
        rst = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [19:0] exp_w [2];
        exp_w[0] = 20'h1A001;
        exp_w[1] = 20'h2B002;
        load_word(5'd0, 20'h1A001);
        load_word(5'd1, 20'h2B002);
        load_word(5'd2, 20'hF0000);
        start = 1'b1; step(); start = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || pc !== 5'd0) begin
            bad++;
            $display("FAIL basic_first_latency: got v=%b pc=%0d want v=0 pc=0", instr_valid, pc);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            total++;
            if ({instruction, instr_valid, pc, issue_count} !== {exp_w[k], 1'b1, 5'(k + 1), 8'(k + 1)}) begin
                bad++;
                $display("FAIL basic_issue%0d: got instr=%h v=%b pc=%0d cnt=%0d want %h/1/%0d/%0d",
                         k, instruction, instr_valid, pc, issue_count, exp_w[k], k + 1, k + 1);
            end
        end
        step();
        total++;
        if ({instruction, instr_valid, halted, issue_count, pc} !== {20'h0, 1'b0, 1'b1, 8'd2, 5'd2}) begin
            bad++;
            $display("FAIL basic_halt: got instr=%h v=%b h=%b cnt=%0d pc=%0d want 0/0/1/2/2",
                     instruction, instr_valid, halted, issue_count, pc);
        end
        step();
        total++;
        if ({instruction, instr_valid, halted, pc} !== {20'h0, 1'b0, 1'b1, 5'd2}) begin
            bad++;
            $display("FAIL basic_halt_hold: got instr=%h v=%b h=%b pc=%0d want 0/0/1/2",
                     instruction, instr_valid, halted, pc);
        end
        $display("test_basic done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 32; i++) load_word(5'(i), fill_word(i));
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            step();
            total++;
            if ({instruction, instr_valid, pc} !== {fill_word((k - 1) % 32), 1'b1, 5'(k % 32)}) begin
                bad++;
                $display("FAIL wrap_cycle%0d: got instr=%h v=%b pc=%0d want %h/1/%0d",
                         k, instruction, instr_valid, pc, fill_word((k - 1) % 32), k % 32);
            end
        end
        abort = 1'b1; step(); abort = 1'b0;
        total++;
        if ({instr_valid, halted, pc, issue_count} !== {1'b0, 1'b0, 5'd2, 8'd34}) begin
            bad++;
            $display("FAIL wrap_abort: got v=%b h=%b pc=%0d cnt=%0d want 0/0/2/34",
                     instr_valid, halted, pc, issue_count);
        end
        $display("test_wrap done");
    endtask

    task automatic test_stall();
        start = 1'b1; step(); start = 1'b0;
        step();
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if ({instruction, instr_valid, pc, issue_count} !== {20'h0, 1'b0, 5'd2, 8'd2}) begin
                bad++;
                $display("FAIL stall_bubble%0d: got instr=%h v=%b pc=%0d cnt=%0d want 0/0/2/2",
                         k, instruction, instr_valid, pc, issue_count);
            end
        end
        stall = 1'b0;
        step();
        total++;
        if ({instruction, instr_valid, pc, issue_count} !== {20'h10002, 1'b1, 5'd3, 8'd3}) begin
            bad++;
            $display("FAIL stall_resume: got instr=%h v=%b pc=%0d cnt=%0d want 10002/1/3/3",
                     instruction, instr_valid, pc, issue_count);
        end
        abort = 1'b1; step(); abort = 1'b0;
        $display("test_stall done");
    endtask

    task automatic test_load_in_run();
        load_word(5'd6, 20'hF0000);
        start = 1'b1; step(); start = 1'b0;
        step();
        load_en = 1'b1; load_addr = 5'd5; load_data = 20'h12345;
        step();
        load_en = 1'b0;
        for (int k = 0; k < 4; k++) step();
        total++;
        if ({instruction, instr_valid} !== {20'h10005, 1'b1}) begin
            bad++;
            $display("FAIL run_write_ignored: got instr=%h v=%b want 10005/1", instruction, instr_valid);
        end
        step();
        total++;
        if ({halted, issue_count, pc} !== {1'b1, 8'd6, 5'd6}) begin
            bad++;
            $display("FAIL halt_at6: got h=%b cnt=%0d pc=%0d want 1/6/6", halted, issue_count, pc);
        end
        load_word(5'd5, 20'h12345);
        total++;
        if ({halted, instr_valid, pc} !== {1'b1, 1'b0, 5'd6}) begin
            bad++;
            $display("FAIL halt_load_hold: got h=%b v=%b pc=%0d want 1/0/6", halted, instr_valid, pc);
        end
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        total++;
        if ({instruction, instr_valid, pc} !== {20'h12345, 1'b1, 5'd6}) begin
            bad++;
            $display("FAIL halt_write_taken: got instr=%h v=%b pc=%0d want 12345/1/6",
                     instruction, instr_valid, pc);
        end
        step();
        $display("test_load_in_run done");
    endtask

    task automatic test_abort_start_halt();
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre_halt: got h=%b want 1", halted);
        end
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        total++;
        if ({halted, instr_valid, pc} !== {1'b0, 1'b0, 5'd6}) begin
            bad++;
            $display("FAIL abort_over_start: got h=%b v=%b pc=%0d want 0/0/6", halted, instr_valid, pc);
        end
        step();
        total++;
        if ({instr_valid, pc, issue_count} !== {1'b0, 5'd6, 8'd6}) begin
            bad++;
            $display("FAIL abort_stays_idle: got v=%b pc=%0d cnt=%0d want 0/6/6", instr_valid, pc, issue_count);
        end
        $display("test_abort_start_halt done");
    endtask

    task automatic test_async_reset();
        load_word(5'd6, fill_word(6));
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 7; k++) step();
        total++;
        if ({instruction, instr_valid, pc, issue_count} !== {20'h10006, 1'b1, 5'd7, 8'd7}) begin
            bad++;
            $display("FAIL areset_pre: got instr=%h v=%b pc=%0d cnt=%0d want 10006/1/7/7",
                     instruction, instr_valid, pc, issue_count);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({instruction, instr_valid, pc, halted, issue_count} !== {20'h0, 1'b0, 5'd0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL areset_immediate: got instr=%h v=%b pc=%0d h=%b cnt=%0d want 0/0/0/0/0",
                     instruction, instr_valid, pc, halted, issue_count);
        end
        #3 rst = 1'b1;
        for (int k = 0; k < 3; k++) step();
        total++;
        if ({instr_valid, pc, halted, issue_count} !== {1'b0, 5'd0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL areset_idle: got v=%b pc=%0d h=%b cnt=%0d want 0/0/0/0",
                     instr_valid, pc, halted, issue_count);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_load_start_same();
        load_en = 1'b1; load_addr = 5'd0; load_data = 20'h3C0DE; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        step();
        total++;
        if ({instruction, instr_valid, pc} !== {20'h3C0DE, 1'b1, 5'd1}) begin
            bad++;
            $display("FAIL load_with_start: got instr=%h v=%b pc=%0d want 3C0DE/1/1",
                     instruction, instr_valid, pc);
        end
        abort = 1'b1; step(); abort = 1'b0;
        $display("test_load_start_same done");
    endtask

    task automatic test_saturation();
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            step();
            if (k == 254 || k == 255 || k == 256) begin
                total++;
                if (issue_count !== 8'((k > 255) ? 255 : k)) begin
                    bad++;
                    $display("FAIL sat_cycle%0d: got cnt=%0d want %0d", k, issue_count, (k > 255) ? 255 : k);
                end
            end
        end
        total++;
        if ({instruction, instr_valid, pc, issue_count} !== {20'h10003, 1'b1, 5'd4, 8'd255}) begin
            bad++;
            $display("FAIL sat_end: got instr=%h v=%b pc=%0d cnt=%0d want 10003/1/4/255",
                     instruction, instr_valid, pc, issue_count);
        end
        $display("test_saturation done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_load_in_run();
        test_abort_start_halt();
        test_async_reset();
        test_load_start_same();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
